// File: rtl/sm_pkg.sv
// Shared types and constants for the sign-magnitude accumulator datapath.
package sm_pkg;

    localparam int unsigned DATA_W  = 23;
    localparam int unsigned MAG_W   = DATA_W - 1;
    localparam int unsigned N_TERMS = 8;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned ACC_W   = MAG_W + CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Sign-magnitude to two's complement; negative zero maps to 0.
    function automatic logic signed [MAG_W:0] sm_to_tc(input logic [DATA_W-1:0] sm);
        logic signed [MAG_W:0] mag_s;
        mag_s = $signed({1'b0, sm[MAG_W-1:0]});
        return sm[DATA_W-1] ? -mag_s : mag_s;
    endfunction

endpackage

// File: rtl/sm_sat_pack.sv
// Signed accumulator -> sign-magnitude word. SM_ACC_SAT_EN selects clipping
// (with sat flag) over low-bit truncation.
module sm_sat_pack
    import sm_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc_c,
    output logic        [DATA_W-1:0] sm_c,
    output logic                     sat_c
);

    localparam logic [MAG_W-1:0] MAG_MAX = '1;

    logic             neg;
    logic [ACC_W-1:0] abs_v;
    logic [MAG_W-1:0] mag;
    logic             over;

    always_comb begin
        neg   = acc_c[ACC_W-1];
        abs_v = neg ? ACC_W'(-acc_c) : ACC_W'(acc_c);
        over  = |abs_v[ACC_W-1:MAG_W];
`ifdef SM_ACC_SAT_EN
        mag   = over ? MAG_MAX : abs_v[MAG_W-1:0];
        sat_c = over;
`else
        mag   = abs_v[MAG_W-1:0];
        sat_c = 1'b0;
`endif
        // A zero magnitude is never emitted with the sign bit set.
        sm_c  = {neg && (mag != '0), mag};
    end

`ifndef SM_ACC_SAT_EN
    logic unused_over;
    assign unused_over = over;
`endif

endmodule

// File: rtl/sm_accumulator.sv
// Groups N_TERMS sign-magnitude terms into one sign-magnitude sum.
// Build option: SM_ACC_SAT_EN enables output saturation.
module sm_accumulator
    import sm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat,
    output logic              busy
);

    localparam int unsigned CNT_QW = CNT_W + 1;

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [CNT_QW-1:0] cnt_q, cnt_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic        [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_sat_q, out_sat_d;
    logic                     busy_q, busy_d;

    logic signed [MAG_W:0]    term_tc;
    logic signed [ACC_W-1:0]  term_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic        [CNT_QW-1:0] cnt_inc;
    logic                     last_term;
    logic        [DATA_W-1:0] pack_data;
    logic                     pack_sat;

    always_comb begin
        term_tc   = sm_to_tc(in_data);
        term_ext  = $signed({{(ACC_W-MAG_W-1){term_tc[MAG_W]}}, term_tc});
        acc_sum   = acc_q + term_ext;
        cnt_inc   = cnt_q + CNT_QW'(1);
        last_term = (cnt_inc == CNT_QW'(N_TERMS));
    end

    sm_sat_pack u_sat_pack (
        .acc_c (acc_sum),
        .sm_c  (pack_data),
        .sat_c (pack_sat)
    );

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;

        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (in_valid) begin
                    acc_d   = term_ext;
                    cnt_d   = CNT_QW'(1);
                    state_d = ACC;
                end
            end
            ACC: begin
                if (clr) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (in_valid) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if (last_term) begin
                        out_data_d = pack_data;
                        out_sat_d  = pack_sat;
                        state_d    = OUT;
                    end
                end
            end
            OUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d != OUT);
        out_valid_d = (state_d == OUT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sm_accumulator.sv
// Directed self-checking bench for sm_accumulator (honours SM_ACC_SAT_EN).
module tb_sm_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [22:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] out_data;
    logic        out_sat;
    logic        busy;

    int n_checks;
    int n_errors;

    sm_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%06h expected 0x%06h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one term and hold it until accepted.
    task automatic push(input logic [22:0] d);
        int budget;
        in_data  = d;
        in_valid = 1'b1;
        budget   = 0;
        while (!in_ready && budget < 50) begin
            tick();
            budget++;
        end
        if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // Wait for the sum, check it, complete the handshake.
    task automatic take(input string tag, input logic [22:0] exp_d, input logic exp_s);
        int budget;
        budget = 0;
        while (!out_valid && budget < 50) begin
            tick();
            budget++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp_d));
        check({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic push_n(input logic [22:0] d, input int n);
        for (int i = 0; i < n; i++) push(d);
    endtask

    logic [22:0] big_exp;
    logic        big_sat;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Eight +1 terms back-to-back; sum appears after the 8th transfer.
        push_n(23'h000001, 7);
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_early", 32'(out_valid), 32'd0);
        push(23'h000001);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_in_ready", 32'(in_ready), 32'd0);
        take("ones", 23'h000008, 1'b0);

        push_n(23'd100, 4);
        push_n(23'h40001E, 4);
        take("mixed", 23'h000118, 1'b0);

        push(23'h400005);
        push(23'h000007);
        push(23'h400007);
        push(23'h400000);
        push_n(23'h000000, 4);
        take("neg", 23'h400005, 1'b0);

        push(23'h000007);
        push(23'h400007);
        push_n(23'h000000, 6);
        take("zero", 23'h000000, 1'b0);

`ifdef SM_ACC_SAT_EN
        big_exp = 23'h3FFFFF;
        big_sat = 1'b1;
`else
        big_exp = 23'h3FFFF8;
        big_sat = 1'b0;
`endif
        push_n(23'h3FFFFF, 8);
        take("big", big_exp, big_sat);

        // Back-pressure: terms offered while the sum waits must be refused.
        push_n(23'h000001, 8);
        in_valid = 1'b1;
        in_data  = 23'h000005;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_data", 32'(out_data), 32'h000008);
        end
        in_valid = 1'b0;
        in_data  = '0;
        take("bp", 23'h000008, 1'b0);
        push_n(23'h000003, 8);
        take("bp_next", 23'h000018, 1'b0);

        // clr in OUT is ignored.
        push_n(23'h000001, 8);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_out_kept", 32'(out_valid), 32'd1);
        take("clr_out", 23'h000008, 1'b0);

        // Reset mid-group.
        push_n(23'h000009, 3);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        push_n(23'h000002, 8);
        take("after_rst", 23'h000010, 1'b0);

        // clr mid-group with a same-cycle term that must be dropped.
        push_n(23'h000009, 3);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 23'h000005;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_valid", 32'(out_valid), 32'd0);
        push_n(23'h000002, 8);
        take("after_clr", 23'h000010, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sm_accumulator.md
# sm_accumulator

Sequential accumulator for 23-bit sign-magnitude values: one sign bit, 22-bit magnitude. It accepts a group of N_TERMS terms over a valid/ready stream and sums them in a wide two's-complement register. It then emits the group sum in sign-magnitude form, saturated, over a second valid/ready stream. It sits on the neuron datapath downstream of the sign-magnitude adder stage, draining its results into one neuron sum.

## Interface
- DATA_W, 23, word width; bit DATA_W-1 is sign, bits DATA_W-2:0 are magnitude
- N_TERMS, 8, terms per group (≥2)
- CNT_W, 3, term counter width, ≥ clog2(N_TERMS)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous abort; discards partial group
- in_valid  in  1  term present
- in_ready  out  1  block can take a term
- in_data  in  DATA_W  sign-magnitude term
- out_valid  out  1  group sum present
- out_ready  in  1  consumer takes sum
- out_data  out  DATA_W  sign-magnitude group sum
- out_sat  out  1  sum was clipped (qualified by out_valid)
- busy  out  1  at least one term of the current group accepted

## Operation
- States: IDLE, ACC, OUT.
- IDLE:
  - in_ready=1.
  - A transfer (in_valid&&in_ready) loads acc with the term, sets cnt=1 and goes to ACC.
- ACC:
  - in_ready=1; each transfer does acc += term and cnt++.
  - The transfer that makes cnt==N_TERMS goes to OUT.
- OUT:
  - in_ready=0; out_valid=1; out_data and out_sat are held stable.
  - out_valid&&out_ready returns to IDLE and clears acc and cnt.
- Term conversion:
  - Positive term: +mag; negative term: −mag, as two's complement.
  - Negative zero (0x400000) is treated as 0.
- acc width is MAG_W+CNT_W+1 = 26 bits signed. No internal overflow is possible.
- Output conversion:
  - sign = acc<0; magnitude = |acc|.
  - A zero sum is always emitted as 0x000000, never as negative zero.
- Magnitude above 2^22−1 is handled per Configuration.
- clr:
  - In IDLE or ACC, returns to IDLE, zeroes acc and cnt, and discards any same-cycle transfer.
  - In OUT, clr is ignored.
- busy=1 in ACC and OUT, 0 in IDLE.

## Timing
- Reset values: state=IDLE, acc=0, cnt=0, in_ready=1, out_valid=0, out_data=0, out_sat=0, busy=0.
- One term is accepted per cycle in IDLE/ACC.
- out_valid rises on the cycle after the N_TERMS-th transfer (1-cycle latency).
- out_data and out_sat are registered and change only on entry to OUT.
- Minimum group period is N_TERMS+1 cycles. The output handshake cycle returns to IDLE, so in_ready reasserts the following cycle.
- in_ready is a function of state only, with no combinational path from out_ready.
- Reset mid-group or in OUT aborts immediately. The next group starts from zero.

## Configuration
- SM_ACC_SAT_EN defined:
  - |acc| > 0x3FFFFF clips the magnitude to 0x3FFFFF, keeping the sign.
  - out_sat=1 for that result.
- SM_ACC_SAT_EN undefined:
  - The magnitude is truncated to its low 22 bits, keeping the sign.
  - out_sat is tied to 0.
  - A truncated-to-zero result is emitted as 0x000000.

## Structure
- Shared package sm_pkg holds:
  - DATA_W and MAG_W=DATA_W−1.
  - State enum {IDLE, ACC, OUT}.
  - Function sm_to_tc, sign-magnitude to signed.
- One sub-module, sm_sat_pack: combinational signed acc → sign-magnitude word plus sat flag. It contains the SM_ACC_SAT_EN logic.
- The FSM, counter and accumulator live in sm_accumulator.

## Test plan
- Eight terms 0x000001, back-to-back with out_ready=1 → out_data=0x000008, out_sat=0, out_valid on cycle 9 after the first transfer.
- Four terms of +100 then four of −30 (0x40001E) → out_data=0x000118 (+280).
- Terms −5, +7, −7 (0x400007), 0x400000, then four zeros → out_data=0x400005. A group of +7, −7, six zeros → 0x000000 exactly.
- Eight terms of 0x3FFFFF:
  - With SM_ACC_SAT_EN → out_data=0x3FFFFF, out_sat=1.
  - Without SM_ACC_SAT_EN → out_data=0x3FFFF8, out_sat=0.
- Group completes, out_ready held 0 for 5 cycles while in_valid=1:
  - out_data stable, in_ready=0, no term accepted.
  - out_ready=1 → next cycle in_ready=1 and the next group sums correctly.
- Abort cases:
  - After 3 terms, assert rst_n=0 for one cycle (separately, clr=1) → busy=0, out_valid=0.
  - A following group of eight 0x000002 terms yields 0x000010.
